// File: rtl/arb_pkg.sv
// Shared defaults and grant encoding for the core instruction/data memory arbiter.
package arb_pkg;

  localparam int unsigned ARB_ADDR_W     = 32;
  localparam int unsigned ARB_DATA_W     = 32;
  localparam int unsigned ARB_MAX_CONSEC = 4;
  localparam int unsigned ARB_CNT_W      = 4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_D    = 2'd2
  } grant_t;

endpackage

// File: rtl/arb_fair_cnt.sv
// Saturating count of consecutive data grants taken while a fetch is waiting.
module arb_fair_cnt
  import arb_pkg::*;
#(
  parameter int unsigned MAX_CONSEC = ARB_MAX_CONSEC
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [ARB_CNT_W-1:0] CNT_MAX = ARB_CNT_W'(MAX_CONSEC);

  logic [ARB_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + ARB_CNT_W'(1);
    end
  end

  assign at_max = (cnt == CNT_MAX);

endmodule

// File: rtl/core_mem_arbiter.sv
// Arbitrates instruction fetch and load/store requests onto one single-port memory,
// routing the one-cycle-later read data back to the port that won.
module core_mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ARB_ADDR_W,
  parameter int unsigned DATA_W     = ARB_DATA_W,
  parameter int unsigned MAX_CONSEC = ARB_MAX_CONSEC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  input  logic [3:0]        d_req_wstrb,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  grant_t gnt;
  logic   at_max;
  logic   cnt_inc;
  logic   cnt_clr;
  logic   rsp_pend;
  logic   rsp_sel;
  logic   rsp_we;

  // Gating with rst keeps ready/mem_en low for the whole reset window, not just after an edge.
  always_comb begin
    gnt = GNT_NONE;
    if (rst && mem_ready) begin
      if (d_req_valid && (!if_req_valid || !at_max)) begin
        gnt = GNT_D;
      end else if (if_req_valid) begin
        gnt = GNT_IF;
      end
    end
  end

  assign if_req_ready = (gnt == GNT_IF);
  assign d_req_ready  = (gnt == GNT_D);

  assign cnt_inc = (gnt == GNT_D) && if_req_valid;
  assign cnt_clr = (gnt == GNT_IF) || !if_req_valid;

  arb_fair_cnt #(
    .MAX_CONSEC(MAX_CONSEC)
  ) u_fair_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .at_max(at_max)
  );

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    case (gnt)
      GNT_IF: begin
        mem_en   = 1'b1;
        mem_addr = {if_req_addr[ADDR_W-1:2], 2'b00};
      end
      GNT_D: begin
        mem_en    = 1'b1;
        mem_we    = d_req_we;
        mem_addr  = d_req_addr;
        mem_wdata = d_req_wdata;
        mem_wstrb = d_req_we ? d_req_wstrb : 4'b0000;
      end
      default: ;
    endcase
  end

  // rsp_we lets a store acknowledge with zero data instead of whatever mem_rdata shows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_pend <= 1'b0;
      rsp_sel  <= 1'b0;
      rsp_we   <= 1'b0;
    end else begin
      rsp_pend <= (gnt != GNT_NONE);
      rsp_sel  <= (gnt == GNT_D);
      rsp_we   <= (gnt == GNT_D) && d_req_we;
    end
  end

  assign if_rsp_valid = rsp_pend && !rsp_sel;
  assign d_rsp_valid  = rsp_pend && rsp_sel;
  assign if_rsp_data  = if_rsp_valid ? mem_rdata : '0;
  assign d_rsp_data   = (d_rsp_valid && !rsp_we) ? mem_rdata : '0;

endmodule

// File: doc/core_mem_arbiter.md
CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter MAX_CONSEC, default 4, max consecutive data grants while a fetch waits (range 1..15).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 if_req_valid  input  1; if_req_ready  output  1; if_req_addr  input  ADDR_W.  Fetch request.
REQ-007 if_rsp_valid  output  1; if_rsp_data  output  DATA_W.  Fetch response.
REQ-008 d_req_valid  input  1; d_req_ready  output  1; d_req_we  input  1; d_req_addr  input  ADDR_W; d_req_wdata  input  DATA_W; d_req_wstrb  input  4.  Load/store request.
REQ-009 d_rsp_valid  output  1; d_rsp_data  output  DATA_W.  Load/store response.
REQ-010 mem_en  output  1; mem_we  output  1; mem_addr  output  ADDR_W; mem_wdata  output  DATA_W; mem_wstrb  output  4.  Single-port memory command.
REQ-011 mem_ready  input  1  memory accepts a command this cycle; mem_rdata  input  DATA_W, valid exactly one cycle after an accepted command.

Function
REQ-012 Request accepted on a port when valid && ready in the same cycle; at most one acceptance per cycle.
REQ-013 Both ready outputs SHALL be 0 while mem_ready is 0.
REQ-014 Only d_req pending: d_req_ready = mem_ready; only if_req pending: if_req_ready = mem_ready.
REQ-015 Both pending: data wins unless consec count = MAX_CONSEC, then fetch wins.
REQ-016 Consec counter: +1 on each data grant while if_req_valid is 1; cleared on any fetch grant or any cycle if_req_valid is 0; saturates at MAX_CONSEC.
REQ-017 mem_en = 1 exactly in acceptance cycles; mem_* fields combinationally copy the winner's fields.
REQ-018 Fetch: mem_we = 0, mem_wstrb = 0, mem_addr low two bits forced to 00.
REQ-019 Data: mem_we = d_req_we, mem_wstrb = d_req_we ? d_req_wstrb : 0, address passed unmodified.
REQ-020 Response one cycle after acceptance on the winning port: rsp_valid pulse one cycle, rsp_data = mem_rdata.
REQ-021 Data writes also return d_rsp_valid one cycle later, d_rsp_data = 0.
REQ-022 Back-to-back acceptance allowed: accept in cycle N+1 while response of cycle N is presented.
REQ-023 Response routing held in registered tag (rsp_pend, rsp_sel); if_rsp_valid and d_rsp_valid never both 1.
REQ-024 rsp_data outputs SHALL be 0 whenever corresponding rsp_valid is 0.
REQ-025 Requesters SHALL hold valid and fields stable until accepted; arbiter does not buffer requests.

Reset
REQ-026 rst low: rsp_pend, rsp_sel, consec counter cleared immediately; if_rsp_valid, d_rsp_valid, mem_en, both ready outputs = 0.
REQ-027 Response pending when reset asserts SHALL be dropped, never delivered.
REQ-028 First acceptance possible in the first rising edge with rst high.

Structure
REQ-029 Package arb_pkg SHALL hold ADDR_W/DATA_W defaults, MAX_CONSEC default, enum grant_t {GNT_NONE, GNT_IF, GNT_D}.
REQ-030 Consec counter SHALL be sub-module arb_fair_cnt (inputs: inc, clr; output: at_max).
REQ-031 Grant decode combinational; only rsp tag and counter registered.

Verification
REQ-032 Only fetch, addr 0x0000_0106, mem_ready 1, mem_rdata 0xDEAD_BEEF -> mem_addr 0x104, if_rsp_valid next cycle with 0xDEAD_BEEF.
REQ-033 Both valid continuously, MAX_CONSEC 4 -> grant sequence D,D,D,D,IF,D,D,D,D,IF.
REQ-034 Store addr 0x200, wdata 0x1234_5678, wstrb 0011 -> mem_we 1, mem_wstrb 0011, d_rsp_valid next cycle with data 0.
REQ-035 mem_ready 0 for 3 cycles with both valid -> no ready, no mem_en; first grant on cycle 4 to data.
REQ-036 Load accepted, rst low next cycle before edge -> d_rsp_valid never asserts; after release, new load completes in 2 cycles.
REQ-037 Alternating fetch/load every cycle -> one response per cycle, correct port each cycle, never both rsp_valid.
